// File: rtl/dmem_if.sv
// Request/response channel between a load/store client (master) and dmem_lsu (slave).
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store unit over a word-wide data memory with byte lanes,
// misalignment/range checking and a fixed, parameterised response latency.
module dmem_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 1
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  WaitInit = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, err, we;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   word, wdata_rep, load_val;
    logic [3:0]    be;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    assign accept   = bus.req_valid && (state_q == StIdle);
    assign idx      = bus.req_addr[AW+1:2];
    assign lane     = bus.req_addr[1:0];
    assign word     = mem[idx];
    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];
    assign we       = accept && bus.req_write && !err;

    always_comb begin
        err = 1'b0;
        case (bus.req_size)
            2'b00:   err = 1'b0;
            2'b01:   err = lane[0];
            2'b10:   err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        // Any address bit beyond the array span is out of range.
        if ((bus.req_addr >> (AW + 2)) != 32'd0) err = 1'b1;
    end

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        case (bus.req_size)
            2'b00:   load_val = bus.req_unsigned ? {24'b0, byte_sel}
                                                 : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = bus.req_unsigned ? {16'b0, half_sel}
                                                 : {{16{half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    err_d   = err;
                    rdata_d = (bus.req_write || err) ? 32'd0 : load_val;
                    cnt_d   = WaitInit;
                    state_d = (LAT == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) state_d = StResp;
                else               cnt_d   = cnt_q - 2'd1;
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: LAT=1 and LAT=3 instances share one request stream and are checked
// every cycle against a byte-addressed reference memory, plus literal directed cases.
module tb_dmem_lsu;
    localparam int unsigned Depth = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b0;

    dmem_if bus1 ();
    dmem_if bus3 ();

    assign bus1.req_valid    = req_valid;
    assign bus1.req_write    = req_write;
    assign bus1.req_size     = req_size;
    assign bus1.req_unsigned = req_unsigned;
    assign bus1.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus1.resp_ready   = resp_ready;
    assign bus3.req_valid    = req_valid;
    assign bus3.req_write    = req_write;
    assign bus3.req_size     = req_size;
    assign bus3.req_unsigned = req_unsigned;
    assign bus3.req_addr     = req_addr;
    assign bus3.req_wdata    = req_wdata;
    assign bus3.resp_ready   = resp_ready;

    dmem_lsu #(.DEPTH_WORDS(Depth), .LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    dmem_lsu #(.DEPTH_WORDS(Depth), .LAT(3)) u_lat3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // Reference model: byte-addressed memory and per-instance pending response.
    logic [7:0]  mm [4*Depth];
    bit          pend [2];
    int          acc [2];
    logic [31:0] erd [2];
    logic        eerr [2];
    bit          ev [2];
    int          lat [2] = '{1, 3};
    logic [31:0] m_rd;
    logic        m_er;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void model_req(input logic wr, input logic [1:0] sz, input logic uns,
                                      input logic [31:0] a, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || ((a % 32'(n)) != 32'd0) || (a >= 32'(4 * Depth));
        rd = 32'd0;
        v  = 32'd0;
        if (!er) begin
            for (int k = 0; k < n; k++) begin
                if (wr) mm[a + 32'(k)] = wd[8*k +: 8];
                else    v = v | (32'(mm[a + 32'(k)]) << (8 * k));
            end
            if (!wr) begin
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endfunction

    function automatic void check_dut(input int i, input string nm, input logic rdy,
                                      input logic vld, input logic [31:0] rd, input logic er);
        ev[i] = pend[i] && (cyc >= acc[i] + lat[i] - 1);
        chk({nm, "_req_ready"}, 32'(rdy), 32'(!pend[i]));
        chk({nm, "_resp_valid"}, 32'(vld), 32'(ev[i]));
        if (ev[i]) begin
            chk({nm, "_resp_rdata"}, rd, erd[i]);
            chk({nm, "_resp_err"}, 32'(er), 32'(eerr[i]));
        end
    endfunction

    // Compare process: inputs change only just after posedge, so at negedge they show
    // what the next edge will do.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend[0] = 1'b0;
                pend[1] = 1'b0;
                chk("rst1_valid", 32'(bus1.resp_valid), 32'd0);
                chk("rst1_rdata", bus1.resp_rdata, 32'd0);
                chk("rst1_err", 32'(bus1.resp_err), 32'd0);
                chk("rst3_valid", 32'(bus3.resp_valid), 32'd0);
                chk("rst3_rdata", bus3.resp_rdata, 32'd0);
                chk("rst3_err", 32'(bus3.resp_err), 32'd0);
            end else begin
                check_dut(0, "lat1", bus1.req_ready, bus1.resp_valid, bus1.resp_rdata,
                          bus1.resp_err);
                check_dut(1, "lat3", bus3.req_ready, bus3.resp_valid, bus3.resp_rdata,
                          bus3.resp_err);
                if (req_valid && (!pend[0] || !pend[1])) begin
                    model_req(req_write, req_size, req_unsigned, req_addr, req_wdata, m_rd, m_er);
                    for (int i = 0; i < 2; i++) begin
                        if (!pend[i]) begin
                            pend[i] = 1'b1;
                            acc[i]  = cyc + 1;
                            erd[i]  = m_rd;
                            eerr[i] = m_er;
                        end
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    if (ev[i] && resp_ready) pend[i] = 1'b0;
                end
            end
        end
    end

    // One transaction on both instances; junk requests are offered while both are busy.
    task automatic xact(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int l1, output int l3);
        int  a0;
        int  c;
        bit  done;
        req_valid = 1'b1;  req_write = wr;  req_size = sz;
        req_unsigned = uns;  req_addr = a;  req_wdata = wd;
        @(posedge clk); #1;
        a0 = cyc;  req_valid = 1'b0;
        l1 = 0;  l3 = 0;  done = 1'b0;  c = 0;  rd = 32'd0;  er = 1'b0;
        while (!done && c < hold + 20) begin
            if (bus1.resp_valid && l1 == 0) l1 = cyc - a0 + 1;
            if (bus3.resp_valid && l3 == 0) l3 = cyc - a0 + 1;
            if (c < hold) begin
                req_valid = 1'($urandom_range(0, 1));
                req_write = 1'($urandom_range(0, 1));
                req_size = 2'($urandom_range(0, 3));
                req_addr = $urandom_range(0, 127);
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
                resp_ready = 1'b1;
                if (bus3.resp_valid) begin
                    rd = bus3.resp_rdata;
                    er = bus3.resp_err;
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        resp_ready = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL resp_timeout: got no response, required one within %0d cycles",
                     hold + 20);
        end
    endtask

    task automatic run(input string nm, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic        er;
        int          l1, l3;
        xact(wr, sz, uns, a, wd, 0, rd, er, l1, l3);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          l1, l3, vcnt;
        logic [31:0] a;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", bus3.resp_rdata, 32'd0);
        chk("reset_valid", 32'(bus3.resp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("reset_ready", 32'(bus3.req_ready), 32'd1);

        for (int w = 0; w < 32; w++) xact(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, rd, er, l1, l3);

        xact(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, rd, er, l1, l3);
        chk("sw10_err", 32'(er), 32'd0);
        chk("sw10_lat1", 32'(l1), 32'd1);
        run("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
        run("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAA_AA7F, 32'd0, 1'b0);
        run("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEAD_7FEF, 1'b0);
        run("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 32'hFFFF_FFDE, 1'b0);
        run("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 32'h0000_00DE, 1'b0);
        run("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'd0, 32'hFFFF_DEAD, 1'b0);
        run("lhu12", 1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 32'h0000_DEAD, 1'b0);
        run("lh11", 1'b0, 2'd1, 1'b0, 32'h11, 32'd0, 32'd0, 1'b1);
        run("sw12", 1'b1, 2'd2, 1'b0, 32'h12, 32'h1234_5678, 32'd0, 1'b1);
        run("lw10c", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hDEAD_7FEF, 1'b0);
        run("lw1000", 1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, 32'd0, 1'b1);
        run("size11", 1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 32'd0, 1'b1);
        run("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h5555_BEEF, 32'd0, 1'b0);
        run("lw10d", 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 32'hBEEF_7FEF, 1'b0);

        // Backpressure: response held 5 cycles, then handshake.
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5, rd, er, l1, l3);
        chk("bp_rdata", rd, 32'hBEEF_7FEF);
        chk("bp_lat3", 32'(l3), 32'd3);
        chk("bp_lat1", 32'(l1), 32'd1);
        chk("bp_ready_after", 32'(bus3.req_ready), 32'd1);

        // Reset during WAIT of the LAT=3 instance; the accepted store must survive.
        req_valid = 1'b1;  req_write = 1'b1;  req_size = 2'd2;
        req_unsigned = 1'b0;  req_addr = 32'h40;  req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid1", 32'(bus1.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus1.resp_valid || bus3.resp_valid) vcnt++;
            @(posedge clk); #1;
        end
        chk("rst_abandoned", 32'(vcnt), 32'd0);
        chk("rst_ready_after", 32'(bus3.req_ready), 32'd1);
        run("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 32'hCAFE_F00D, 1'b0);

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + $urandom_range(0, 255);
                1:       a = $urandom | 32'h8000_0000;
                default: a = $urandom_range(0, 127);
            endcase
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom, $urandom_range(0, 5), rd, er, l1, l3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
